// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment display driver.
// Converts a binary value to hex or decimal digits (double dabble for decimal)
// and time-multiplexes them across NUM_DIGITS active-low common-enable displays.
// Ports:
//   clk, rstN           - clock, asynchronous active-low reset
//   value               - binary value to display (sampled at accepted frame start)
//   decimalMode         - 1 = decimal, 0 = hex (sampled with value)
//   blankLeadingZeros   - blank zero digits above the most significant nonzero digit
//   dpMask              - per-digit decimal point, 1 = lit (applied live)
//   sevenSegmentData    - {dp,g,f,e,d,c,b,a}, active low
//   sevenSegmentEnable  - one-cold digit enables, digit 0 rightmost
//   busy                - conversion in progress
//   overflow            - last completed conversion did not fit in NUM_DIGITS
module seven_segment_scanner #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned VALUE_WIDTH = 16,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic [VALUE_WIDTH-1:0] value,
  input  logic                   decimalMode,
  input  logic                   blankLeadingZeros,
  input  logic [NUM_DIGITS-1:0]  dpMask,
  output logic [7:0]             sevenSegmentData,
  output logic [NUM_DIGITS-1:0]  sevenSegmentEnable,
  output logic                   busy,
  output logic                   overflow
);

  localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DIV_W      = $clog2(REFRESH_DIV);
  // Ten BCD digits hold any 32-bit value, so the overflow check is a simple
  // look at the digits above NUM_DIGITS.
  localparam int unsigned BCD_DIGITS = 10;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned SHD_W      = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W      = $clog2(VALUE_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEX  = 2'd1,
    S_DEC  = 2'd2
  } state_t;

  state_t               state_q, state_n;
  logic [DIV_W-1:0]     div_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 start_pend_q;
  logic [BCD_W-1:0]     bcd_q;
  logic [VALUE_WIDTH-1:0] bin_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [SHD_W-1:0]     shadow_q;
  logic                 shadow_vld_q;

  logic                 div_tc_c;
  logic                 frame_start_c;
  logic                 load_hex_c;
  logic                 load_dec_c;
  logic                 step_c;
  logic                 commit_c;
  logic [BCD_W-1:0]     bcd_adj_c;
  logic [NUM_DIGITS-1:0] lead_zero_c;
  logic [3:0]           cur_nib_c;
  logic                 cur_dp_c;
  logic                 cur_blank_c;
  logic [7:0]           seg_c;
  logic [NUM_DIGITS-1:0] en_c;

  // Active-low glyphs {g,f,e,d,c,b,a}
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Scan timing: divider terminal count and frame start strobe
  assign div_tc_c      = (div_q == DIV_W'(REFRESH_DIV - 1));
  assign frame_start_c = start_pend_q |
                         (div_tc_c && (idx_q == IDX_W'(NUM_DIGITS - 1)));

  // Divider, digit index and first-edge-after-reset flag
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      div_q        <= '0;
      idx_q        <= '0;
      start_pend_q <= 1'b1;
    end else begin
      start_pend_q <= 1'b0;
      if (div_tc_c) begin
        div_q <= '0;
        if (idx_q == IDX_W'(NUM_DIGITS - 1)) idx_q <= '0;
        else                                 idx_q <= idx_q + IDX_W'(1);
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  // Conversion FSM state register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_n;
      busy    <= (state_n != S_IDLE);
    end
  end

  // Conversion FSM next state; frame starts are only accepted while idle
  always_comb begin
    state_n    = state_q;
    load_hex_c = 1'b0;
    load_dec_c = 1'b0;
    step_c     = 1'b0;
    commit_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start_c) begin
          if (decimalMode) begin
            state_n    = S_DEC;
            load_dec_c = 1'b1;
          end else begin
            state_n    = S_HEX;
            load_hex_c = 1'b1;
          end
        end
      end
      S_HEX: begin
        commit_c = 1'b1;
        state_n  = S_IDLE;
      end
      S_DEC: begin
        if (cnt_q == CNT_W'(VALUE_WIDTH)) begin
          commit_c = 1'b1;
          state_n  = S_IDLE;
        end else begin
          step_c = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Double dabble add-3 correction on every BCD digit
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath; hex loads the value straight into the BCD register
  // so both modes commit through the same path.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bcd_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
    end else if (load_hex_c) begin
      bcd_q <= BCD_W'(value);
    end else if (load_dec_c) begin
      bcd_q <= '0;
      bin_q <= value;
      cnt_q <= '0;
    end else if (step_c) begin
      bcd_q <= BCD_W'({bcd_adj_c, bin_q[VALUE_WIDTH-1]});
      bin_q <= {bin_q[VALUE_WIDTH-2:0], 1'b0};
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Shadow digits and overflow update together when busy falls
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      overflow     <= 1'b0;
    end else if (commit_c) begin
      shadow_q     <= bcd_q[SHD_W-1:0];
      shadow_vld_q <= 1'b1;
      overflow     <= |bcd_q[BCD_W-1:SHD_W];
    end
  end

  // Leading-zero map: bit i set when digits i..NUM_DIGITS-1 are all zero
  always_comb begin
    logic zero_run;
    zero_run    = 1'b1;
    lead_zero_c = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_run       = zero_run & (shadow_q[4*i +: 4] == 4'd0);
      lead_zero_c[i] = zero_run;
    end
  end

  // Select the currently scanned digit
  always_comb begin
    cur_nib_c   = 4'd0;
    cur_dp_c    = 1'b0;
    cur_blank_c = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib_c   = shadow_q[4*i +: 4];
        cur_dp_c    = dpMask[i];
        cur_blank_c = blankLeadingZeros && (i != 0) && lead_zero_c[i];
      end
    end
  end

  // Segment pattern: blank before first commit, dash on overflow
  always_comb begin
    if (!shadow_vld_q)    seg_c = {~cur_dp_c, 7'h7F};
    else if (overflow)    seg_c = {~cur_dp_c, 7'h3F};
    else if (cur_blank_c) seg_c = {~cur_dp_c, 7'h7F};
    else                  seg_c = {~cur_dp_c, glyph(cur_nib_c)};
    en_c = ~(NUM_DIGITS'(1) << idx_q);
  end

  // Registered display outputs; data and enable change on the same edge
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sevenSegmentData   <= 8'hFF;
      sevenSegmentEnable <= '1;
    end else begin
      sevenSegmentData   <= seg_c;
      sevenSegmentEnable <= en_c;
    end
  end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Multiplexed, parametrised seven-segment display driver. Converts an N-bit binary value to hex or decimal digits and time-multiplexes them across NUM_DIGITS common-enable displays. Digits are active-low with per-digit decimal points, leading-zero blanking and overflow indication. It replaces the static DIP-switch-to-display path at the board top level.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8); digit 0 is rightmost.
VALUE_WIDTH, 16, width of the binary input (4..32).
REFRESH_DIV, 50000, clock cycles each digit is enabled; must be > VALUE_WIDTH+2.

Ports:
clk  input  1  system clock.
rstN  input  1  asynchronous, active-low reset.
value  input  VALUE_WIDTH  binary value to display.
decimalMode  input  1  1 = decimal, 0 = hex.
blankLeadingZeros  input  1  1 = blank zero digits above the most significant nonzero digit.
dpMask  input  NUM_DIGITS  per-digit decimal point; 1 = lit.
sevenSegmentData  output  8  segments {dp,g,f,e,d,c,b,a}, active low.
sevenSegmentEnable  output  NUM_DIGITS  digit enables, active low, one-cold.
busy  output  1  conversion in progress.
overflow  output  1  last completed conversion did not fit in NUM_DIGITS.

Behaviour:
- Reset (async, rstN=0):
  - Outputs: sevenSegmentData=8'hFF, sevenSegmentEnable=all 1s, busy=0, overflow=0.
  - Internal: divider=0, digit index=0, shadow digits=blank.
- Scan timing:
  - Divider counts 0..REFRESH_DIV-1. At terminal count, the digit index advances and wraps from NUM_DIGITS-1 to 0.
  - Data and enable are registered and change in the same cycle. Enable bit i is 0 only while digit i is selected.
- Frame start:
  - Occurs on the first clk edge after reset release, and at every wrap of the index to 0.
  - At frame start, value and decimalMode are sampled if busy=0. If busy=1 the frame start is skipped; no queuing.
- Hex conversion:
  - Takes 1 cycle; busy is high for 1 cycle.
  - Nibble i drives digit i.
  - overflow=1 if any bit at position 4*NUM_DIGITS or higher is nonzero.
- Decimal conversion:
  - Sequential shift-add-3 (double dabble); busy is high for exactly VALUE_WIDTH+1 cycles.
  - overflow=1 if value >= 10^NUM_DIGITS.
- Shadow update:
  - Shadow digit registers and overflow update atomically in the cycle busy falls.
  - The previous frame's digits are displayed until that update.
- Overflow display: every digit shows '-' (8'hBF, g only); blanking is ignored.
- Glyphs: 0-9 and A,b,C,d,E,F in the standard forms.
- Blanking: a blanked digit is 8'hFF apart from dp. Digit 0 is never blanked.
- Decimal point: dpMask is applied live, not latched. dp bit = ~dpMask[index].
- Input changes mid-conversion have no effect until the next accepted frame start.
- rstN assertion mid-conversion aborts it; outputs return to reset values immediately (asynchronous).

Test Plan:
Bench configuration: NUM_DIGITS=4, VALUE_WIDTH=16, REFRESH_DIV=32.
1. Reset:
   - Hold rstN=0 for 5 cycles -> data=8'hFF, enable=4'b1111, busy=0, overflow=0.
   - Release rstN -> busy=1 for 1 cycle (hex).
2. Hex scan: value=16'hBEEF, decimalMode=0, dpMask=0 ->
   - Enables 1110,1101,1011,0111, each for 32 cycles.
   - Data 8'h8E, 8'h86, 8'h86, 8'h83 respectively.
   - Enable wraps to 1110 after 128 cycles.
3. Decimal conversion: value=16'd1234, decimalMode=1 ->
   - busy=1 for 17 cycles.
   - Digits 0..3 = 8'h99, 8'hB0, 8'hA4, 8'hF9.
   - overflow=0.
4. Decimal overflow: value=16'd10000, decimalMode=1 -> overflow=1; all digits 8'hBF.
   - Then value=16'd9999 -> next frame clears overflow; all digits 8'h90.
5. Leading-zero blanking: value=16'd7, decimalMode=1, dpMask=4'b0100.
   - blankLeadingZeros=1 -> digit0=8'hF8, digit1=8'hFF, digit2=8'h7F, digit3=8'hFF.
   - blankLeadingZeros=0 -> digits 1,3 = 8'hC0; digit2 = 8'h40.
6. Reset mid-conversion: drop rstN 5 cycles into a decimal conversion -> same cycle (async): data=8'hFF, enable=4'b1111, busy=0.
   - After release: conversion restarts and completes after 17 cycles with correct digits.
